ulpb_event_collector: RTL and testbench

//  Synthesizable N-channel handshake responder and event logger for ULPB bus ports.

---
 rtl/ulpb_event_collector.sv | 206 ++++++++++++++++++++
 tb/tb_ulpb_event_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_event_collector.sv
// N-port ULPB handshake responder: completes RX/RX-fail/TX-response 4-phase handshakes
// and logs every completed event into a show-ahead FIFO drained by a valid/ready consumer.
module ulpb_event_collector #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int DROP_ON_FULL = 1,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic [NUM_CH-1:0]            AUTO_ACK_EN,
    input  logic [NUM_CH-1:0]            RX_REQ,
    input  logic [NUM_CH-1:0]            RX_FAIL,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [NUM_CH*DATA_WIDTH-1:0] RX_DATA,
    output logic [NUM_CH-1:0]            RX_ACK,
    input  logic [NUM_CH-1:0]            TX_SUCC,
    input  logic [NUM_CH-1:0]            TX_FAIL,
    output logic [NUM_CH-1:0]            TX_RESP_ACK,
    output logic                         EVT_VALID,
    input  logic                         EVT_READY,
    output logic [CHW-1:0]               EVT_CHAN,
    output logic [1:0]                   EVT_TYPE,
    output logic [ADDR_WIDTH-1:0]        EVT_ADDR,
    output logic [DATA_WIDTH-1:0]        EVT_DATA,
    output logic                         OVERFLOW,
    input  logic                         CLR_OVF
);

    localparam int NREQ = 2 * NUM_CH;
    localparam int PW   = $clog2(NREQ);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = CHW + 2 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {ST_IDLE, ST_ACK} hs_state_t;

    hs_state_t rx_st_q [NUM_CH];
    hs_state_t rx_st_d [NUM_CH];
    hs_state_t tx_st_q [NUM_CH];
    hs_state_t tx_st_d [NUM_CH];

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  drop_ok;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    rr_idx;
    logic             rr_found;
    logic             push;
    logic             pop;
    logic             drop_any;
    logic             full;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [EW-1:0]    ent;
    logic [EW-1:0]    head;

    logic [CHW-1:0]        ent_chan;
    logic [1:0]            ent_type;
    logic [ADDR_WIDTH-1:0] ent_addr;
    logic [DATA_WIDTH-1:0] ent_data;

    // Requesters: even index = RX side of a port, odd index = TX side.
    always_comb begin
        req     = '0;
        drop_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            req[2*c]       = (rx_st_q[c] == ST_IDLE) &&
                             (RX_FAIL[c] || (RX_REQ[c] && AUTO_ACK_EN[c]));
            drop_ok[2*c]   = RX_FAIL[c];
            req[2*c+1]     = (tx_st_q[c] == ST_IDLE) && (TX_SUCC[c] || TX_FAIL[c]);
            drop_ok[2*c+1] = 1'b1;
        end
    end

    always_comb begin : rr_arb
        int j;
        j        = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!rr_found && req[j]) begin
                rr_found = 1'b1;
                rr_idx   = PW'(j);
            end
        end
    end

    assign full = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && EVT_READY;

    // A full FIFO never bypasses on a same-cycle pop; droppable requesters are all acked at once.
    always_comb begin
        gnt      = '0;
        push     = 1'b0;
        drop_any = 1'b0;
        if (!full) begin
            if (rr_found) begin
                gnt[rr_idx] = 1'b1;
                push        = 1'b1;
            end
        end else if (DROP_ON_FULL != 0) begin
            gnt      = req & drop_ok;
            drop_any = |gnt;
        end
    end

    always_comb begin
        ent_chan = CHW'(rr_idx >> 1);
        ent_addr = '0;
        ent_data = '0;
        if (rr_idx[0]) begin
            ent_type = TX_SUCC[ent_chan] ? 2'b10 : 2'b11;
        end else if (RX_FAIL[ent_chan]) begin
            ent_type = 2'b01;
        end else begin
            ent_type = 2'b00;
            ent_addr = RX_ADDR[ent_chan*ADDR_WIDTH +: ADDR_WIDTH];
            ent_data = RX_DATA[ent_chan*DATA_WIDTH +: DATA_WIDTH];
        end
        ent = {ent_chan, ent_type, ent_addr, ent_data};
    end

    // Port handshake FSMs: state register
    always_ff @(posedge CLK) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!RESETn) begin
                rx_st_q[c] <= ST_IDLE;
                tx_st_q[c] <= ST_IDLE;
            end else begin
                rx_st_q[c] <= rx_st_d[c];
                tx_st_q[c] <= tx_st_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rx_st_d[c] = rx_st_q[c];
            tx_st_d[c] = tx_st_q[c];
            case (rx_st_q[c])
                ST_IDLE: if (gnt[2*c]) rx_st_d[c] = ST_ACK;
                ST_ACK:  if (!RX_REQ[c] && !RX_FAIL[c]) rx_st_d[c] = ST_IDLE;
                default: rx_st_d[c] = ST_IDLE;
            endcase
            case (tx_st_q[c])
                ST_IDLE: if (gnt[2*c+1]) tx_st_d[c] = ST_ACK;
                ST_ACK:  if (!TX_SUCC[c] && !TX_FAIL[c]) tx_st_d[c] = ST_IDLE;
                default: tx_st_d[c] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            RX_ACK[c]      = (rx_st_q[c] == ST_ACK);
            TX_RESP_ACK[c] = (tx_st_q[c] == ST_ACK);
        end
    end

    // Control state: arbiter pointer, FIFO pointers/count, sticky overflow
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push)
                ptr_q <= (rr_idx == PW'(NREQ-1)) ? '0 : rr_idx + PW'(1);
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)
                count_q <= count_q + (AW+1)'(1);
            else if (pop && !push)
                count_q <= count_q - (AW+1)'(1);
            if (drop_any)
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr_q] <= ent;
    end

    // Head is gated by valid so stale storage never reaches the outputs.
    assign head      = mem[rd_ptr_q];
    assign EVT_VALID = (count_q != '0);
    assign EVT_CHAN  = EVT_VALID ? head[EW-1 -: CHW] : '0;
    assign EVT_TYPE  = EVT_VALID ? head[ADDR_WIDTH+DATA_WIDTH +: 2] : 2'b00;
    assign EVT_ADDR  = EVT_VALID ? head[DATA_WIDTH +: ADDR_WIDTH] : '0;
    assign EVT_DATA  = EVT_VALID ? head[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_ulpb_event_collector.sv
// Directed bench for ulpb_event_collector: one drop-on-full instance and one wait-on-full
// instance share the same stimulus.
module tb_ulpb_event_collector;

    logic         CLK;
    logic         RESETn;
    logic [3:0]   AUTO_ACK_EN;
    logic [3:0]   RX_REQ;
    logic [3:0]   RX_FAIL;
    logic [31:0]  RX_ADDR;
    logic [127:0] RX_DATA;
    logic [3:0]   TX_SUCC;
    logic [3:0]   TX_FAIL;
    logic         EVT_READY;
    logic         CLR_OVF;

    logic [3:0]   rx_ack,    rx_ack_w;
    logic [3:0]   tx_ack,    tx_ack_w;
    logic         evt_valid, evt_valid_w;
    logic [1:0]   evt_chan,  evt_chan_w;
    logic [1:0]   evt_type,  evt_type_w;
    logic [7:0]   evt_addr,  evt_addr_w;
    logic [31:0]  evt_data,  evt_data_w;
    logic         ovf,       ovf_w;

    int checks = 0;
    int errors = 0;

    ulpb_event_collector #(.NUM_CH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                           .FIFO_DEPTH(8), .DROP_ON_FULL(1)) dut (
        .CLK(CLK), .RESETn(RESETn), .AUTO_ACK_EN(AUTO_ACK_EN),
        .RX_REQ(RX_REQ), .RX_FAIL(RX_FAIL), .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA),
        .RX_ACK(rx_ack), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(tx_ack),
        .EVT_VALID(evt_valid), .EVT_READY(EVT_READY), .EVT_CHAN(evt_chan),
        .EVT_TYPE(evt_type), .EVT_ADDR(evt_addr), .EVT_DATA(evt_data),
        .OVERFLOW(ovf), .CLR_OVF(CLR_OVF)
    );

    ulpb_event_collector #(.NUM_CH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                           .FIFO_DEPTH(8), .DROP_ON_FULL(0)) dut_wait (
        .CLK(CLK), .RESETn(RESETn), .AUTO_ACK_EN(AUTO_ACK_EN),
        .RX_REQ(RX_REQ), .RX_FAIL(RX_FAIL), .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA),
        .RX_ACK(rx_ack_w), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(tx_ack_w),
        .EVT_VALID(evt_valid_w), .EVT_READY(EVT_READY), .EVT_CHAN(evt_chan_w),
        .EVT_TYPE(evt_type_w), .EVT_ADDR(evt_addr_w), .EVT_DATA(evt_data_w),
        .OVERFLOW(ovf_w), .CLR_OVF(CLR_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1;
    endtask

    initial begin
        RESETn = 1'b0; AUTO_ACK_EN = 4'hF; RX_REQ = '0; RX_FAIL = '0;
        RX_ADDR = '0; RX_DATA = '0; TX_SUCC = '0; TX_FAIL = '0;
        EVT_READY = 1'b1; CLR_OVF = 1'b0;
        tick();
        tick();
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_rx_ack", rx_ack, 4'h0);
        chk("rst_tx_ack", tx_ack, 4'h0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_chan", evt_chan, 2'd0);
        chk("rst_data", evt_data, 32'h0);
        RESETn = 1'b1;

        // Single RX transaction on port 2
        RX_ADDR[23:16] = 8'hB0;
        RX_DATA[95:64] = 32'hDEADBEEF;
        RX_REQ[2] = 1'b1;
        tick();
        chk("t1_ack", rx_ack, 4'b0100);
        chk("t1_valid", evt_valid, 1'b1);
        chk("t1_chan", evt_chan, 2'd2);
        chk("t1_type", evt_type, 2'b00);
        chk("t1_addr", evt_addr, 8'hB0);
        chk("t1_data", evt_data, 32'hDEADBEEF);
        RX_REQ[2] = 1'b0;
        tick();
        chk("t1_ack_fall", rx_ack, 4'h0);
        chk("t1_popped", evt_valid, 1'b0);

        // Simultaneous burst, round-robin order from pointer 0
        do_reset();
        RX_ADDR = 32'h13121110;
        RX_REQ = 4'hF;
        tick();
        chk("t2_ack0", rx_ack, 4'b0001);
        chk("t2_chan0", evt_chan, 2'd0);
        chk("t2_addr0", evt_addr, 8'h10);
        tick();
        chk("t2_ack1", rx_ack, 4'b0011);
        chk("t2_chan1", evt_chan, 2'd1);
        tick();
        chk("t2_ack2", rx_ack, 4'b0111);
        chk("t2_chan2", evt_chan, 2'd2);
        tick();
        chk("t2_ack3", rx_ack, 4'b1111);
        chk("t2_chan3", evt_chan, 2'd3);
        RX_REQ = 4'h0;
        tick();
        chk("t2_drain", evt_valid, 1'b0);
        RX_REQ = 4'hF;
        tick();
        chk("t2_wrap_ack", rx_ack, 4'b0001);
        chk("t2_wrap_chan", evt_chan, 2'd0);
        tick(); tick(); tick();
        RX_REQ = 4'h0;
        tick();
        chk("t2_wrap_drain", evt_valid, 1'b0);

        // Fill the FIFO, then a ninth RX request must stall until a pop
        EVT_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RX_DATA[31:0] = i;
            RX_REQ[0] = 1'b1;
            tick();
            chk("t3_fill_ack", rx_ack[0], 1'b1);
            RX_REQ[0] = 1'b0;
            tick();
        end
        RX_DATA[31:0] = 32'd8;
        RX_REQ[0] = 1'b1;
        tick();
        chk("t3_full_ack", rx_ack[0], 1'b0);
        tick();
        chk("t3_full_ack2", rx_ack[0], 1'b0);
        chk("t3_head", evt_data, 32'd0);
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        chk("t3_no_bypass", rx_ack[0], 1'b0);
        tick();
        chk("t3_late_ack", rx_ack[0], 1'b1);
        chk("t3_head_next", evt_data, 32'd1);
        chk("t3_ovf", ovf, 1'b0);
        RX_REQ[0] = 1'b0;
        tick();

        // Full FIFO and a TX failure response: dropped vs withheld
        TX_FAIL[1] = 1'b1;
        tick();
        chk("t4_drop_ack", tx_ack, 4'b0010);
        chk("t4_drop_ovf", ovf, 1'b1);
        chk("t4_drop_head", evt_data, 32'd1);
        chk("t4_wait_ack", tx_ack_w, 4'b0000);
        chk("t4_wait_ovf", ovf_w, 1'b0);
        tick();
        chk("t4_ovf_sticky", ovf, 1'b1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("t4_ovf_clr", ovf, 1'b0);
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        chk("t4_wait_no_bypass", tx_ack_w, 4'b0000);
        tick();
        chk("t4_wait_ack_late", tx_ack_w, 4'b0010);
        TX_FAIL[1] = 1'b0;
        tick();
        chk("t4_drop_ack_fall", tx_ack, 4'b0000);
        chk("t4_wait_ack_fall", tx_ack_w, 4'b0000);
        EVT_READY = 1'b1;
        repeat (7) tick();
        chk("t4_drop_count", evt_valid, 1'b0);
        chk("t4_wait_count", evt_valid_w, 1'b1);
        chk("t4_wait_chan", evt_chan_w, 2'd1);
        chk("t4_wait_type", evt_type_w, 2'b11);
        chk("t4_wait_data", evt_data_w, 32'd0);
        tick();
        chk("t4_wait_empty", evt_valid_w, 1'b0);

        // RX_REQ ignored while auto-ack is disabled for the port
        do_reset();
        AUTO_ACK_EN = 4'b1101;
        RX_REQ[1] = 1'b1;
        tick();
        tick();
        chk("aa_ack", rx_ack, 4'h0);
        chk("aa_valid", evt_valid, 1'b0);
        RX_REQ[1] = 1'b0;
        AUTO_ACK_EN = 4'hF;

        // RX_FAIL and RX_REQ together on port 3
        EVT_READY = 1'b0;
        RX_ADDR[31:24] = 8'hAA;
        RX_DATA[127:96] = 32'h12345678;
        RX_FAIL[3] = 1'b1;
        RX_REQ[3] = 1'b1;
        tick();
        chk("t5_ack", rx_ack, 4'b1000);
        chk("t5_chan", evt_chan, 2'd3);
        chk("t5_type", evt_type, 2'b01);
        chk("t5_data", evt_data, 32'h0);
        chk("t5_addr", evt_addr, 8'h0);
        RX_REQ[3] = 1'b0;
        tick();
        chk("t5_ack_held", rx_ack, 4'b1000);
        EVT_READY = 1'b1;
        tick();
        chk("t5_single_evt", evt_valid, 1'b0);
        chk("t5_ack_held2", rx_ack, 4'b1000);
        RX_FAIL[3] = 1'b0;
        tick();
        chk("t5_ack_fall", rx_ack, 4'h0);

        // Reset in mid-handshake with entries queued
        EVT_READY = 1'b0;
        RX_DATA[31:0] = 32'h600D0000;
        RX_REQ = 4'b0111;
        tick(); tick(); tick();
        chk("t6_pre_ack", rx_ack, 4'b0111);
        chk("t6_pre_valid", evt_valid, 1'b1);
        RESETn = 1'b0;
        tick();
        chk("t6_rst_ack", rx_ack, 4'h0);
        chk("t6_rst_valid", evt_valid, 1'b0);
        chk("t6_rst_chan", evt_chan, 2'd0);
        RESETn = 1'b1;
        tick();
        chk("t6_reack", rx_ack, 4'b0001);
        chk("t6_relog_chan", evt_chan, 2'd0);
        chk("t6_relog_data", evt_data, 32'h600D0000);
        RX_REQ = 4'h0;
        EVT_READY = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
